// File: rtl/gf_inv_pipe_if.sv
// Byte stream (valid/ready) carrying one composite-field GF((2^4)^2) element.
// Sideband tag exists only when GFINV_TAG_EN is defined.
interface gf_inv_pipe_if #(parameter int TAG_W = 4);
  // A beat transfers on a rising clk edge where valid && ready; the master holds
  // valid/data stable until it transfers, and ready never depends on valid.
  logic       valid;
  logic       ready;
  logic [7:0] data;
`ifdef GFINV_TAG_EN
  logic [TAG_W-1:0] tag;
  modport master (output valid, output data, output tag, input ready);
  modport slave  (input valid, input data, input tag, output ready);
`else
  localparam int unused_tag_w = TAG_W;
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
`endif
endinterface

// File: rtl/gf_inv_pipe.sv
// 3-stage GF((2^4)^2) inverter (GF(2^4): x^4+x+1, extension X^2+X+lambda, lambda=4'hC).
// Optional macro GFINV_TAG_EN carries a sideband tag in lock-step with each byte.
module gf_inv_pipe #(
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  gf_inv_pipe_if.slave  in_i,
  gf_inv_pipe_if.master out_o
);

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] aa;
    r  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      r  = r ^ (aa & {4{b[i]}});
      aa = {aa[2:0], 1'b0} ^ (4'h3 & {4{aa[3]}});
    end
    return r;
  endfunction

  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h1: r = 4'h1;  4'h2: r = 4'h9;  4'h3: r = 4'hE;  4'h4: r = 4'hD;
      4'h5: r = 4'hB;  4'h6: r = 4'h7;  4'h7: r = 4'h6;  4'h8: r = 4'hF;
      4'h9: r = 4'h2;  4'hA: r = 4'hC;  4'hB: r = 4'h5;  4'hC: r = 4'hA;
      4'hD: r = 4'h4;  4'hE: r = 4'h3;  4'hF: r = 4'h8;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  localparam logic [3:0] LAMBDA = 4'hC;

  logic       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [3:0] ah1_q, ah1_d, sum1_q, sum1_d, d1_q, d1_d;
  logic [3:0] ah2_q, ah2_d, sum2_q, sum2_d, dinv2_q, dinv2_d;
  logic [7:0] out_q, out_d;
  logic       s1_load, s2_load, s3_load;
  logic [3:0] in_ah, in_al;

  // Each stage refills whenever it is empty or its successor drains it, so bubbles collapse.
  assign s3_load   = !v3_q || out_o.ready;
  assign s2_load   = !v2_q || s3_load;
  assign s1_load   = !v1_q || s2_load;
  assign in_i.ready = s1_load;

  assign in_ah = in_i.data[7:4];
  assign in_al = in_i.data[3:0];

  always_comb begin
    v1_d    = v1_q;   ah1_d  = ah1_q;  sum1_d  = sum1_q;  d1_d = d1_q;
    v2_d    = v2_q;   ah2_d  = ah2_q;  sum2_d  = sum2_q;  dinv2_d = dinv2_q;
    v3_d    = v3_q;   out_d  = out_q;
    if (s1_load) begin
      v1_d   = in_i.valid;
      ah1_d  = in_ah;
      sum1_d = in_ah ^ in_al;
      d1_d   = gf4_mul(in_ah ^ in_al, in_al) ^ gf4_mul(LAMBDA, gf4_mul(in_ah, in_ah));
    end
    if (s2_load) begin
      v2_d    = v1_q;
      ah2_d   = ah1_q;
      sum2_d  = sum1_q;
      dinv2_d = gf4_inv(d1_q);
    end
    if (s3_load) begin
      v3_d  = v2_q;
      out_d = {gf4_mul(ah2_q, dinv2_q), gf4_mul(sum2_q, dinv2_q)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;  ah1_q <= 4'h0;  sum1_q <= 4'h0;  d1_q <= 4'h0;
      v2_q <= 1'b0;  ah2_q <= 4'h0;  sum2_q <= 4'h0;  dinv2_q <= 4'h0;
      v3_q <= 1'b0;  out_q <= 8'h00;
    end else begin
      v1_q <= v1_d;  ah1_q <= ah1_d;  sum1_q <= sum1_d;  d1_q <= d1_d;
      v2_q <= v2_d;  ah2_q <= ah2_d;  sum2_q <= sum2_d;  dinv2_q <= dinv2_d;
      v3_q <= v3_d;  out_q <= out_d;
    end
  end

  assign out_o.valid = v3_q;
  assign out_o.data  = out_q;

`ifdef GFINV_TAG_EN
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
    end else begin
      if (s1_load) tag1_q <= in_i.tag;
      if (s2_load) tag2_q <= tag1_q;
      if (s3_load) tag3_q <= tag2_q;
    end
  end

  assign out_o.tag = tag3_q;
`else
  localparam int unused_tag_w = TAG_W;
`endif

endmodule

// File: tb/tb_gf_inv_pipe.sv
// Directed + random bench for gf_inv_pipe; reference inverse found by brute-force search
// over composite-field multiplication.
module tb_gf_inv_pipe;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf_inv_pipe_if #(.TAG_W(TAG_W)) in_if ();
  gf_inv_pipe_if #(.TAG_W(TAG_W)) out_if ();

  gf_inv_pipe #(.TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .in_i (in_if),
    .out_o(out_if)
  );

  int         checks = 0;
  int         errors = 0;
  int         out_cnt = 0;
  int         acc_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] inv_tbl[256];
`ifdef GFINV_TAG_EN
  logic [TAG_W-1:0] tag_q[$];
`endif

  function automatic logic [3:0] gf4_mul_ref(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (32'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [7:0] gf8_mul_ref(input logic [7:0] x, input logic [7:0] y);
    logic [3:0] hh, hi, lo;
    hh = gf4_mul_ref(x[7:4], y[7:4]);
    hi = hh ^ gf4_mul_ref(x[7:4], y[3:0]) ^ gf4_mul_ref(x[3:0], y[7:4]);
    lo = gf4_mul_ref(4'hC, hh) ^ gf4_mul_ref(x[3:0], y[3:0]);
    return {hi, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes that complete on the coming edge, then step past it.
  task automatic tick();
    logic [7:0] e, s;
    @(negedge clk);
    if (!rst && out_if.valid && out_if.ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_out", {24'h0, out_if.data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        s = src_q.pop_front();
        check("out_data", {24'h0, out_if.data}, {24'h0, e});
        if (s != 8'h00) check("x_times_inv", {24'h0, gf8_mul_ref(s, out_if.data)}, 32'h1);
`ifdef GFINV_TAG_EN
        check("out_tag", {28'h0, out_if.tag}, {28'h0, tag_q.pop_front()});
`endif
      end
    end
    if (!rst && in_if.valid && in_if.ready) begin
      acc_cnt++;
      exp_q.push_back(inv_tbl[in_if.data]);
      src_q.push_back(in_if.data);
`ifdef GFINV_TAG_EN
      tag_q.push_back(in_if.tag);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] t);
    in_if.valid = v;
    in_if.data  = d;
`ifdef GFINV_TAG_EN
    in_if.tag   = t;
`else
    if (t == 4'hF) in_if.data = d;
`endif
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    drive(1'b0, 8'h00, 4'h0);
    out_if.ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  logic [7:0] t1_in [4] = '{8'h00, 8'h01, 8'h02, 8'h10};
  logic [7:0] t1_out[4] = '{8'h00, 8'h01, 8'h09, 8'hAA};

  initial begin
    logic [7:0] hold;
    int         base, n, acc0;

    for (int x = 0; x < 256; x++) inv_tbl[x] = 8'h00;
    for (int x = 1; x < 256; x++)
      for (int y = 1; y < 256; y++)
        if (gf8_mul_ref(8'(x), 8'(y)) == 8'h01) inv_tbl[x] = 8'(y);

    // Reset state
    rst = 1'b1;
    out_if.ready = 1'b1;
    drive(1'b0, 8'h00, 4'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", {31'h0, out_if.valid}, 0);
    check("rst_out_data", {24'h0, out_if.data}, 0);
    check("rst_in_ready", {31'h0, in_if.ready}, 1);
`ifdef GFINV_TAG_EN
    check("rst_out_tag", {28'h0, out_if.tag}, 0);
`endif

    // T1: single beats, fixed values and 3-cycle latency
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, t1_in[k], 4'(k));
      check("t1_in_ready", {31'h0, in_if.ready}, 1);
      tick();
      drive(1'b0, 8'h00, 4'h0);
      n = 0;
      while (!out_if.valid && n < 10) begin
        tick();
        n++;
      end
      check("t1_latency", n, 2);
      check("t1_value", {24'h0, out_if.data}, {24'h0, t1_out[k]});
      tick();
    end

    // T2: all 256 bytes back-to-back, outputs without gaps once filled
    base = out_cnt;
    for (int x = 0; x < 256; x++) begin
      drive(1'b1, 8'(x), 4'(x));
      tick();
    end
    drive(1'b0, 8'h00, 4'h0);
    check("t2_stream_count", out_cnt - base, 253);
    repeat (3) tick();
    check("t2_total_count", out_cnt - base, 256);

    // T3: backpressure fills exactly 3 stages and freezes the output
    out_if.ready = 1'b0;
    acc0 = acc_cnt;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      tick();
    end
    check("t3_accepts", acc_cnt - acc0, 3);
    check("t3_in_ready_low", {31'h0, in_if.ready}, 0);
    hold = out_if.data;
    check("t3_head_value", {24'h0, hold}, {24'h0, exp_q[0]});
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_valid_held", {31'h0, out_if.valid}, 1);
      check("t3_data_frozen", {24'h0, out_if.data}, {24'h0, hold});
    end
    drain("t3_drain", 20);

    // T4/T6: random valid/ready with random data and tags
    acc0 = acc_cnt;
    n = 0;
    while (acc_cnt - acc0 < 10000 && n < 60000) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      out_if.ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("t4_sent", (acc_cnt - acc0 >= 10000) ? 1 : 0, 1);
    drain("t4_drain", 50);

    // T5: reset with 3 bytes in flight discards them
    out_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'($urandom_range(1, 255)), 4'(k));
      tick();
    end
    drive(1'b0, 8'h00, 4'h0);
    check("t5_full", {31'h0, out_if.valid}, 1);
    rst = 1'b1;
    tick();
    check("t5_valid_after_rst", {31'h0, out_if.valid}, 0);
    exp_q.delete();
    src_q.delete();
`ifdef GFINV_TAG_EN
    tag_q.delete();
`endif
    rst = 1'b0;
    out_if.ready = 1'b1;
    base = out_cnt;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t5_no_stale", {31'h0, out_if.valid}, 0);
    end
    check("t5_no_output", out_cnt - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
